// File: rtl/dds_pkg.sv
// dds_pkg: shared waveform encodings, unity amplitude and default sizes for the multi-channel DDS
package dds_pkg;
    typedef enum logic [1:0] {WAVE_SAW, WAVE_SIN, WAVE_SQU, WAVE_TRI} wave_t;
    localparam int DEF_NCH = 2;
    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_AMP_W = 8;
    function automatic int unity(input int amp_w);
        return 1 << amp_w;
    endfunction
    localparam int AMP_UNITY = unity(DEF_AMP_W);
endpackage

// File: rtl/dds_multi_if.sv
// dds_multi_if: configuration valid/ready request port with error pulse
interface dds_multi_if import dds_pkg::*; #(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int AMP_W = DEF_AMP_W
);
    logic valid, ready, sync, err;
    logic [7:0] ch;
    logic [PHASE_W-1:0] freq, phase;
    logic [1:0] wave;
    logic [AMP_W:0] amp;
    modport master(output valid, ch, freq, phase, wave, amp, sync, input ready, err);
    modport slave(input valid, ch, freq, phase, wave, amp, sync, output ready, err);
endinterface

// File: rtl/dds_chan.sv
// dds_chan: one DDS channel - accumulator, deferred-update shadow and the 3-stage sample pipeline
module dds_chan import dds_pkg::*; #(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMP_W = DEF_AMP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               wr,
    input  logic               wr_sync,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  wave_t              cfg_wave,
    input  logic [AMP_W:0]     cfg_amp,
    input  logic [DATA_W-1:0]  sin_data,
    output logic               pending,
    output logic [ADDR_W-1:0]  sin_addr,
    output logic [DATA_W-1:0]  dout
);
    localparam int PW = DATA_W + AMP_W + 3;
    localparam logic [AMP_W:0] AMP_ONE = (AMP_W+1)'(unity(AMP_W));
    logic [PHASE_W-1:0] acc, freq, off, sh_freq, sh_off, ph_full;
    logic [PHASE_W:0] sum;
    wave_t wave, sh_wave;
    logic [AMP_W:0] amp, sh_amp;
    logic [DATA_W:0] ph;
    logic [DATA_W-1:0] smp, smp_next, tri_v;
    logic signed [DATA_W:0] d;
    logic signed [PW-1:0] prod, res;
    logic commit;
    assign sum = {1'b0, acc} + {1'b0, freq};
    assign commit = pending && (clr || (en && sum[PHASE_W]));
    assign ph_full = acc + off;
    assign tri_v = ph[DATA_W-1:0];
    assign smp_next = wave == WAVE_SAW ? ph[DATA_W -: DATA_W] :
                      wave == WAVE_SIN ? sin_data :
                      wave == WAVE_SQU ? {DATA_W{~ph[DATA_W]}} :
                      ph[DATA_W] ? ~tri_v : tri_v;
    // Centre on midscale, scale by amp with a floor shift, then re-centre
    assign d = $signed({1'b0, smp}) - $signed({2'b01, {(DATA_W-1){1'b0}}});
    assign prod = PW'(d) * PW'($signed({1'b0, amp}));
    assign res = (prod >>> AMP_W) + PW'(2 ** (DATA_W - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            freq <= '0;
            off <= '0;
            wave <= WAVE_SAW;
            amp <= AMP_ONE;
            pending <= 1'b0;
            ph <= '0;
            sin_addr <= '0;
            smp <= '0;
            dout <= '0;
        end else begin
            acc <= clr ? '0 : en ? sum[PHASE_W-1:0] : acc;
            pending <= wr_sync || (pending && !commit);
            if (wr_sync) begin
                sh_freq <= cfg_freq;
                sh_off <= cfg_phase;
                sh_wave <= cfg_wave;
                sh_amp <= cfg_amp;
            end
            if (wr) begin
                freq <= cfg_freq;
                off <= cfg_phase;
                wave <= cfg_wave;
                amp <= cfg_amp;
            end else if (commit) begin
                freq <= sh_freq;
                off <= sh_off;
                wave <= sh_wave;
                amp <= sh_amp;
            end
            ph <= (DATA_W+1)'(ph_full >> (PHASE_W - DATA_W - 1));
            sin_addr <= ADDR_W'(ph_full >> (PHASE_W - ADDR_W));
            smp <= smp_next;
            dout <= res[PW-1] ? '0 : |res[PW-2:DATA_W] ? '1 : res[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/dds_multi.sv
// dds_multi: NCH-channel phase-accumulator DDS with per-channel immediate or wrap-synchronous configuration
module dds_multi import dds_pkg::*; #(
    parameter int NCH = DEF_NCH,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMP_W = DEF_AMP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    phase_clr,
    dds_multi_if.slave              cfg,
    output logic [NCH*ADDR_W-1:0]   sin_addr,
    input  logic [NCH*DATA_W-1:0]   sin_data,
    output logic [NCH*DATA_W-1:0]   dout,
    output logic                    dout_valid
);
    localparam logic [7:0] NCH8 = 8'(NCH);
    logic [NCH-1:0] pending;
    logic [2:0] vs;
    logic take;
    // Out-of-range channels are always ready so the request drains and flags cfg_err
    always_comb begin
        cfg.ready = 1'b1;
        for (int i = 0; i < NCH; i++) if (cfg.ch == 8'(i) && pending[i]) cfg.ready = 1'b0;
    end
    assign take = cfg.valid && cfg.ready;
    assign dout_valid = vs[2];
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg.err <= 1'b0;
            vs <= '0;
        end else begin
            cfg.err <= take && cfg.ch >= NCH8;
            vs <= {vs[1:0], 1'b1};
        end
    end
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        dds_chan #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AMP_W(AMP_W)) u_chan (
            .clk(clk),
            .rst(rst),
            .en(en),
            .clr(phase_clr),
            .wr(take && cfg.ch == 8'(c) && !cfg.sync),
            .wr_sync(take && cfg.ch == 8'(c) && cfg.sync),
            .cfg_freq(cfg.freq),
            .cfg_phase(cfg.phase),
            .cfg_wave(wave_t'(cfg.wave)),
            .cfg_amp(cfg.amp),
            .sin_data(sin_data[c*DATA_W +: DATA_W]),
            .pending(pending[c]),
            .sin_addr(sin_addr[c*ADDR_W +: ADDR_W]),
            .dout(dout[c*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_dds_multi.sv
// tb_dds_multi: vector table plus queue scoreboard driven by a behavioural channel model
module tb_dds_multi;
    localparam int NCH = 2;
    logic clk = 1'b0;
    logic rst, en, phase_clr, dout_valid;
    logic [NCH*10-1:0] sin_addr;
    logic [NCH*8-1:0] sin_data, dout;
    int n_chk = 0, n_err = 0;

    dds_multi_if #(.PHASE_W(32), .AMP_W(8)) cfg_if ();
    dds_multi #(.NCH(NCH), .PHASE_W(32), .ADDR_W(10), .DATA_W(8), .AMP_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .cfg(cfg_if),
        .sin_addr(sin_addr), .sin_data(sin_data), .dout(dout), .dout_valid(dout_valid));

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [9:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    always_comb for (int c = 0; c < NCH; c++) sin_data[c*8 +: 8] = rom(sin_addr[c*10 +: 10]);

    typedef struct packed {
        logic [NCH-1:0] chk;
        logic [NCH-1:0][7:0] v;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0] w;
        logic [8:0] a;
        logic [31:0] off;
        logic [7:0] exp;
    } vec_t;
    localparam int NV = 13;
    vec_t vt[NV];

    logic [31:0] m_acc[NCH], m_freq[NCH], m_off[NCH], s_freq[NCH], s_off[NCH];
    logic [1:0] m_wave[NCH], s_wave[NCH];
    logic [8:0] m_amp[NCH], s_amp[NCH];
    logic [9:0] m_sa[NCH];
    logic m_pend[NCH];
    logic [2:0] m_vs;
    logic m_err;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] f_out(input logic [31:0] ph, input logic [1:0] w, input logic [8:0] a);
        logic [7:0] t, nt, s;
        int d, r;
        t = ph[30:23];
        nt = ~t;
        s = w == 2'd0 ? ph[31:24] : w == 2'd1 ? rom(ph[31:22]) :
            w == 2'd2 ? (ph[31] ? 8'd0 : 8'd255) : (ph[31] ? nt : t);
        d = int'(s) - 128;
        r = 128 + ((d * int'(a)) >>> 8);
        return r < 0 ? 8'd0 : r > 255 ? 8'd255 : 8'(r);
    endfunction

    // One clock: check ready before the edge, advance the model at the edge, check outputs after it
    task automatic cyc();
        logic mr, tk, cy, hit, cm;
        logic [31:0] ph, nx;
        logic [1:0] ow;
        logic [8:0] oa;
        exp_t e;
        #1;
        mr = 1'b1;
        if (int'(cfg_if.ch) < NCH) mr = !m_pend[int'(cfg_if.ch)];
        if (!rst) chk("cfg_ready", int'(cfg_if.ready), int'(mr));
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = '0; m_freq[c] = '0; m_off[c] = '0; m_wave[c] = '0;
                m_amp[c] = 9'd256; m_pend[c] = 1'b0; m_sa[c] = '0;
            end
            m_vs = '0;
            m_err = 1'b0;
            sbq.delete();
        end else begin
            tk = cfg_if.valid && mr;
            m_err = tk && int'(cfg_if.ch) >= NCH;
            m_vs = {m_vs[1:0], 1'b1};
            for (int c = 0; c < NCH; c++) begin
                ph = m_acc[c] + m_off[c];
                e.v[c] = f_out(ph, m_wave[c], m_amp[c]);
                e.chk[c] = 1'b1;
                m_sa[c] = ph[31:22];
            end
            sbq.push_back(e);
            for (int c = 0; c < NCH; c++) begin
                {cy, nx} = {1'b0, m_acc[c]} + {1'b0, m_freq[c]};
                cm = m_pend[c] && (phase_clr || (en && cy));
                m_acc[c] = phase_clr ? 32'd0 : en ? nx : m_acc[c];
                hit = tk && int'(cfg_if.ch) == c;
                ow = m_wave[c];
                oa = m_amp[c];
                if (hit && !cfg_if.sync) begin
                    m_freq[c] = cfg_if.freq; m_off[c] = cfg_if.phase; m_wave[c] = cfg_if.wave; m_amp[c] = cfg_if.amp;
                end else if (cm) begin
                    m_freq[c] = s_freq[c]; m_off[c] = s_off[c]; m_wave[c] = s_wave[c]; m_amp[c] = s_amp[c];
                end
                if (hit && cfg_if.sync) begin
                    s_freq[c] = cfg_if.freq; s_off[c] = cfg_if.phase; s_wave[c] = cfg_if.wave; s_amp[c] = cfg_if.amp;
                    m_pend[c] = 1'b1;
                end else if (cm) m_pend[c] = 1'b0;
                // wave/amp are read live downstream, so samples already in flight are not predictable
                if (ow != m_wave[c] || oa != m_amp[c]) begin
                    for (int k = 1; k <= 2 && k <= sbq.size(); k++) begin
                        e = sbq[sbq.size()-k];
                        e.chk[c] = 1'b0;
                        sbq[sbq.size()-k] = e;
                    end
                end
            end
        end
        #1;
        chk("dout_valid", int'(dout_valid), int'(m_vs[2]));
        chk("cfg_err", int'(cfg_if.err), int'(m_err));
        for (int c = 0; c < NCH; c++) chk($sformatf("sin_addr%0d", c), int'(sin_addr[c*10 +: 10]), int'(m_sa[c]));
        if (sbq.size() >= 3) begin
            e = sbq.pop_front();
            for (int c = 0; c < NCH; c++)
                if (e.chk[c]) chk($sformatf("dout%0d", c), int'(dout[c*8 +: 8]), int'(e.v[c]));
        end
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] fr, input logic [31:0] ph,
                             input logic [1:0] w, input logic [8:0] a, input logic s);
        int n;
        cfg_if.valid = 1'b1; cfg_if.ch = 8'(ch); cfg_if.freq = fr; cfg_if.phase = ph;
        cfg_if.wave = w; cfg_if.amp = a; cfg_if.sync = s;
        n = 0;
        #1;
        while (!cfg_if.ready && n < 1000) begin
            cyc();
            n++;
        end
        chk("cfg_accept", int'(cfg_if.ready), 1);
        cyc();
        cfg_if.valid = 1'b0;
    endtask

    initial begin
        logic [7:0] a0;
        int n, wraps;
        vt[0]  = '{2'd0, 9'd256, 32'hFF00_0000, 8'd255};
        vt[1]  = '{2'd0, 9'd128, 32'hFF00_0000, 8'd191};
        vt[2]  = '{2'd0, 9'd128, 32'h0000_0000, 8'd64};
        vt[3]  = '{2'd0, 9'd0,   32'h5500_0000, 8'd128};
        vt[4]  = '{2'd2, 9'd256, 32'h0000_0000, 8'd255};
        vt[5]  = '{2'd2, 9'd256, 32'h8000_0000, 8'd0};
        vt[6]  = '{2'd3, 9'd256, 32'h2000_0000, 8'd64};
        vt[7]  = '{2'd3, 9'd256, 32'hA000_0000, 8'd191};
        vt[8]  = '{2'd0, 9'd384, 32'hFF00_0000, 8'd255};
        vt[9]  = '{2'd0, 9'd384, 32'h0000_0000, 8'd0};
        vt[10] = '{2'd3, 9'd128, 32'hC000_0000, 8'd127};
        vt[11] = '{2'd1, 9'd256, 32'h1234_5678, 8'd237};
        vt[12] = '{2'd0, 9'd256, 32'h8000_0000, 8'd128};
        rst = 1'b1; en = 1'b1; phase_clr = 1'b0;
        cfg_if.valid = 1'b0; cfg_if.ch = '0; cfg_if.freq = '0; cfg_if.phase = '0;
        cfg_if.wave = '0; cfg_if.amp = '0; cfg_if.sync = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        #1;
        chk("rst_ready", int'(cfg_if.ready), 1);

        for (int i = 0; i < NV; i++) begin
            cfg_write(0, 32'd0, vt[i].off, vt[i].w, vt[i].a, 1'b0);
            repeat (4) cyc();
            chk($sformatf("vec%0d", i), int'(dout[7:0]), int'(vt[i].exp));
        end

        cfg_write(0, 32'h0100_0000, 32'd0, 2'd0, 9'd256, 1'b0);
        repeat (5) cyc();
        wraps = 0;
        for (int i = 0; i < 260; i++) begin
            a0 = dout[7:0];
            cyc();
            chk("saw_step", int'(8'(dout[7:0] - a0)), 1);
            if (a0 == 8'd255 && dout[7:0] == 8'd0) wraps++;
        end
        chk("saw_wrap_seen", int'(wraps >= 1), 1);

        n = 0;
        while (m_acc[0] != 32'h8000_0000 && n < 600) begin
            cyc();
            n++;
        end
        chk("def_reach_half", int'(m_acc[0] == 32'h8000_0000), 1);
        cfg_write(0, 32'h0200_0000, 32'd0, 2'd0, 9'd256, 1'b1);
        #1;
        chk("def_ready_low", int'(cfg_if.ready), 0);
        repeat (140) cyc();
        #1;
        chk("def_ready_back", int'(cfg_if.ready), 1);
        a0 = dout[7:0];
        cyc();
        chk("def_step2", int'(8'(dout[7:0] - a0)), 2);

        cfg_write(0, 32'h0100_0000, 32'd0, 2'd2, 9'd256, 1'b0);
        cfg_write(1, 32'h0100_0000, 32'h8000_0000, 2'd2, 9'd256, 1'b0);
        phase_clr = 1'b1;
        cyc();
        phase_clr = 1'b0;
        repeat (6) cyc();
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("sq_complement", int'(dout[15:8]), 255 - int'(dout[7:0]));
        end

        cfg_write(0, 32'h0100_0000, 32'd0, 2'd0, 9'd256, 1'b0);
        cfg_write(1, 32'h0300_0000, 32'd0, 2'd0, 9'd256, 1'b0);
        repeat (37) cyc();
        phase_clr = 1'b1;
        cyc();
        phase_clr = 1'b0;
        cyc();
        chk("clr_addr", int'(sin_addr), 0);
        repeat (2) cyc();
        chk("clr_dout", int'(dout), 0);

        cfg_write(3, 32'hDEAD_BEEF, 32'h1, 2'd1, 9'd5, 1'b0);
        chk("err_pulse", int'(cfg_if.err), 1);
        cyc();
        chk("err_clear", int'(cfg_if.err), 0);
        repeat (5) cyc();

        en = 1'b0;
        cfg_write(1, 32'h0500_0000, 32'd0, 2'd0, 9'd256, 1'b1);
        repeat (20) cyc();
        #1;
        chk("pend_hold_en0", int'(cfg_if.ready), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstmid_dout", int'(dout), 0);
        chk("rstmid_valid", int'(dout_valid), 0);
        #1;
        chk("rstmid_ready", int'(cfg_if.ready), 1);
        en = 1'b1;
        repeat (10) cyc();
        chk("valid_after", int'(dout_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
